ccd_frame_sequencer: RTL and testbench

Frame-level timing controller for the CCD readout path. On a capture request it runs exposure, fires the sensor transfer gate, then alternates vertical line shifts and horizontal pixel readout for every line. It drives the CCD vertical clocks, the AFE framing and clamp strobes, and the CPU parallel-port syncs. Horizontal pixel clocks (H1/H2/RG) are out of scope; this block supplies the line and pixel framing around them.

---
 rtl/ccd_frame_sequencer_pkg.sv | 42 ++++
 rtl/ccd_hline_gen.sv | 77 +++++++
 rtl/ccd_frame_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ccd_frame_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_frame_sequencer_pkg.sv
// Shared definitions for the CCD frame sequencer: state encoding, default timing
// constants and the idle/reset levels of every output.
package ccd_frame_sequencer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_EXPOSE = 3'd1;
    localparam logic [2:0] ST_SG     = 3'd2;
    localparam logic [2:0] ST_VXFER  = 3'd3;
    localparam logic [2:0] ST_HREAD  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_EXPOSE = ST_EXPOSE,
        S_SG     = ST_SG,
        S_VXFER  = ST_VXFER,
        S_HREAD  = ST_HREAD
    } state_e;

    localparam int DEF_PIX_DIV       = 4;
    localparam int DEF_H_TOTAL       = 820;
    localparam int DEF_H_ACTIVE      = 648;
    localparam int DEF_H_CLAMP_START = 660;
    localparam int DEF_H_CLAMP_LEN   = 20;
    localparam int DEF_V_LINES       = 494;
    localparam int DEF_VXFER_LEN     = 120;
    localparam int DEF_SG_LEN        = 240;

    // Transfer gate opens after an 8-cycle settle; HD frames the first 8 pixels.
    localparam int SG_GATE_START = 8;
    localparam int HD_PIXELS     = 8;

    localparam logic IDLE_NXV1  = 1'b1;
    localparam logic IDLE_NXV2  = 1'b0;
    localparam logic IDLE_NXSG2 = 1'b1;
    localparam logic IDLE_VD    = 1'b1;
    localparam logic IDLE_HD    = 1'b1;
    localparam logic IDLE_CLPOB = 1'b1;
    localparam logic IDLE_PBLK  = 1'b0;
    localparam logic IDLE_VSYNC = 1'b0;
    localparam logic IDLE_HSYNC = 1'b0;

endpackage

// File: rtl/ccd_hline_gen.sv
// Pixel divider and pixel counter for one readout line, with registered HD,
// HSYNC and CLPOB decode aligned to the first cycle of the line.
module ccd_hline_gen
    import ccd_frame_sequencer_pkg::*;
#(
    parameter int PIX_DIV       = DEF_PIX_DIV,
    parameter int H_TOTAL       = DEF_H_TOTAL,
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_CLAMP_START = DEF_H_CLAMP_START,
    parameter int H_CLAMP_LEN   = DEF_H_CLAMP_LEN
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic first_i,
    output logic line_end_o,
    output logic hd_o,
    output logic hsync_o,
    output logic clpob_o
);

    localparam int DIV_W = $clog2(PIX_DIV + 1);
    localparam int PIX_W = $clog2(H_TOTAL + 1);

    logic             run_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             hd_q, hsync_q, clpob_q;

    // run_i/first_i describe the coming cycle, so the decode below uses the
    // next pixel position and the strobes land on the same cycle as the state.
    always_comb begin
        div_d = '0;
        pix_d = '0;
        if (run_i && !first_i) begin
            if (div_q == DIV_W'(PIX_DIV - 1)) begin
                div_d = '0;
                pix_d = (pix_q == PIX_W'(H_TOTAL - 1)) ? '0 : pix_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
                pix_d = pix_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q   <= 1'b0;
            div_q   <= '0;
            pix_q   <= '0;
            hd_q    <= IDLE_HD;
            hsync_q <= IDLE_HSYNC;
            clpob_q <= IDLE_CLPOB;
        end else begin
            run_q <= run_i;
            div_q <= div_d;
            pix_q <= pix_d;
            if (run_i) begin
                hd_q    <= !(pix_d < PIX_W'(HD_PIXELS));
                hsync_q <= (pix_d < PIX_W'(H_ACTIVE));
                clpob_q <= !((pix_d >= PIX_W'(H_CLAMP_START)) &&
                             (pix_d < PIX_W'(H_CLAMP_START + H_CLAMP_LEN)));
            end else begin
                hd_q    <= IDLE_HD;
                hsync_q <= IDLE_HSYNC;
                clpob_q <= IDLE_CLPOB;
            end
        end
    end

    assign line_end_o = run_q && (div_q == DIV_W'(PIX_DIV - 1)) &&
                        (pix_q == PIX_W'(H_TOTAL - 1));
    assign hd_o       = hd_q;
    assign hsync_o    = hsync_q;
    assign clpob_o    = clpob_q;

endmodule

// File: rtl/ccd_frame_sequencer.sv
// Frame-level CCD readout sequencer: exposure, transfer gate, then alternating
// vertical shift and horizontal readout for every line. All outputs registered.
module ccd_frame_sequencer
    import ccd_frame_sequencer_pkg::*;
#(
    parameter int PIX_DIV       = DEF_PIX_DIV,
    parameter int H_TOTAL       = DEF_H_TOTAL,
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_CLAMP_START = DEF_H_CLAMP_START,
    parameter int H_CLAMP_LEN   = DEF_H_CLAMP_LEN,
    parameter int V_LINES       = DEF_V_LINES,
    parameter int VXFER_LEN     = DEF_VXFER_LEN,
    parameter int SG_LEN        = DEF_SG_LEN
) (
    input  logic        CLK_60M,
    input  logic        CPU_RST,
    input  logic        start,
    input  logic [15:0] exp_lines,
    input  logic        abort,
    output logic        busy,
    output logic        frame_done,
    output logic        CCD_nXV1,
    output logic        CCD_nXV2,
    output logic        CCD_nXSG2,
    output logic        AFE_VD,
    output logic        AFE_HD,
    output logic        AFE_CLPOB,
    output logic        AFE_PBLK,
    output logic        CPU_VSYNC,
    output logic        CPU_HSYNC,
    output logic [2:0]  dbg_state_o
);

    localparam int LINE_CYC = H_TOTAL * PIX_DIV;
    localparam int EXP_W    = 16 + $clog2(LINE_CYC);
    localparam int SG_W     = $clog2(SG_LEN + 16 + 1);
    localparam int VX_W     = $clog2(VXFER_LEN + 1);
    localparam int LN_W     = $clog2(V_LINES + 1);
    localparam int QTR      = VXFER_LEN / 4;

    state_e           state_q, state_d;
    logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
    logic [SG_W-1:0]  sg_cnt_q, sg_cnt_d;
    logic [VX_W-1:0]  vx_cnt_q, vx_cnt_d;
    logic [LN_W-1:0]  line_cnt_q, line_cnt_d;
    logic             done_d;
    logic             hl_run, hl_first, line_end;

    logic busy_q, done_q, nxv1_q, nxv2_q, nxsg2_q, vd_q, pblk_q, vsync_q;

    // abort overrides everything, including a start seen in IDLE.
    always_comb begin
        state_d    = state_q;
        exp_cnt_d  = exp_cnt_q;
        sg_cnt_d   = sg_cnt_q;
        vx_cnt_d   = vx_cnt_q;
        line_cnt_d = line_cnt_q;
        done_d     = 1'b0;
        hl_first   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (exp_lines == 16'd0) begin
                            state_d  = S_SG;
                            sg_cnt_d = '0;
                        end else begin
                            state_d   = S_EXPOSE;
                            exp_cnt_d = EXP_W'(exp_lines) * EXP_W'(LINE_CYC) - 1'b1;
                        end
                    end
                end
                S_EXPOSE: begin
                    if (exp_cnt_q == '0) begin
                        state_d  = S_SG;
                        sg_cnt_d = '0;
                    end else begin
                        exp_cnt_d = exp_cnt_q - 1'b1;
                    end
                end
                S_SG: begin
                    if (sg_cnt_q == SG_W'(SG_LEN + 15)) begin
                        state_d    = S_VXFER;
                        vx_cnt_d   = '0;
                        line_cnt_d = '0;
                    end else begin
                        sg_cnt_d = sg_cnt_q + 1'b1;
                    end
                end
                S_VXFER: begin
                    if (vx_cnt_q == VX_W'(VXFER_LEN - 1)) begin
                        state_d  = S_HREAD;
                        hl_first = 1'b1;
                    end else begin
                        vx_cnt_d = vx_cnt_q + 1'b1;
                    end
                end
                S_HREAD: begin
                    if (line_end) begin
                        line_cnt_d = line_cnt_q + 1'b1;
                        if (line_cnt_q == LN_W'(V_LINES - 1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d  = S_VXFER;
                            vx_cnt_d = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign hl_run = (state_d == S_HREAD);

    // Outputs decode the next state and counters so they line up with the
    // first cycle of each state.
    always_ff @(posedge CLK_60M or negedge CPU_RST) begin
        if (!CPU_RST) begin
            state_q    <= S_IDLE;
            exp_cnt_q  <= '0;
            sg_cnt_q   <= '0;
            vx_cnt_q   <= '0;
            line_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nxv1_q     <= IDLE_NXV1;
            nxv2_q     <= IDLE_NXV2;
            nxsg2_q    <= IDLE_NXSG2;
            vd_q       <= IDLE_VD;
            pblk_q     <= IDLE_PBLK;
            vsync_q    <= IDLE_VSYNC;
        end else begin
            state_q    <= state_d;
            exp_cnt_q  <= exp_cnt_d;
            sg_cnt_q   <= sg_cnt_d;
            vx_cnt_q   <= vx_cnt_d;
            line_cnt_q <= line_cnt_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
            nxsg2_q    <= !((state_d == S_SG) &&
                            (sg_cnt_d >= SG_W'(SG_GATE_START)) &&
                            (sg_cnt_d <= SG_W'(SG_LEN + 7)));
            vd_q       <= !((state_d == S_SG) && (sg_cnt_d < SG_W'(PIX_DIV)));
            if (state_d == S_VXFER) begin
                nxv1_q <= (vx_cnt_d >= VX_W'(2 * QTR));
                nxv2_q <= (vx_cnt_d >= VX_W'(QTR)) && (vx_cnt_d < VX_W'(3 * QTR));
            end else begin
                nxv1_q <= IDLE_NXV1;
                nxv2_q <= IDLE_NXV2;
            end
            pblk_q     <= (state_d == S_HREAD);
            vsync_q    <= (state_d == S_VXFER) || (state_d == S_HREAD);
        end
    end

    ccd_hline_gen #(
        .PIX_DIV       (PIX_DIV),
        .H_TOTAL       (H_TOTAL),
        .H_ACTIVE      (H_ACTIVE),
        .H_CLAMP_START (H_CLAMP_START),
        .H_CLAMP_LEN   (H_CLAMP_LEN)
    ) u_hline (
        .clk_i      (CLK_60M),
        .rst_ni     (CPU_RST),
        .run_i      (hl_run),
        .first_i    (hl_first),
        .line_end_o (line_end),
        .hd_o       (AFE_HD),
        .hsync_o    (CPU_HSYNC),
        .clpob_o    (AFE_CLPOB)
    );

    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign CCD_nXV1    = nxv1_q;
    assign CCD_nXV2    = nxv2_q;
    assign CCD_nXSG2   = nxsg2_q;
    assign AFE_VD      = vd_q;
    assign AFE_PBLK    = pblk_q;
    assign CPU_VSYNC   = vsync_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// Self-checking bench for ccd_frame_sequencer using a timeline reference model
// that derives every output from the cycle offset within a frame.
module tb_ccd_frame_sequencer;

    localparam int PIX_DIV       = 2;
    localparam int H_TOTAL       = 20;
    localparam int H_ACTIVE      = 12;
    localparam int H_CLAMP_START = 14;
    localparam int H_CLAMP_LEN   = 4;
    localparam int V_LINES       = 4;
    localparam int VXFER_LEN     = 8;
    localparam int SG_LEN        = 6;
    localparam int SG_CYC        = SG_LEN + 16;
    localparam int LINE_CYC      = VXFER_LEN + H_TOTAL * PIX_DIV;
    localparam int W             = 11;
    // {busy, frame_done, nXV1, nXV2, nXSG2, VD, HD, CLPOB, PBLK, VSYNC, HSYNC}
    localparam logic [W-1:0] IDLE_VEC = 11'b00_1_0_1_1_1_1_0_0_0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] exp_lines;
    logic        abort;
    logic        busy, frame_done, nxv1, nxv2, nxsg2, vd, hd, clpob, pblk, vsync, hsync;
    logic [2:0]  dbg_state;
    logic [W-1:0] got;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ccd_frame_sequencer #(
        .PIX_DIV(PIX_DIV), .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
        .H_CLAMP_START(H_CLAMP_START), .H_CLAMP_LEN(H_CLAMP_LEN),
        .V_LINES(V_LINES), .VXFER_LEN(VXFER_LEN), .SG_LEN(SG_LEN)
    ) dut (
        .CLK_60M(clk), .CPU_RST(rst_n), .start(start), .exp_lines(exp_lines),
        .abort(abort), .busy(busy), .frame_done(frame_done),
        .CCD_nXV1(nxv1), .CCD_nXV2(nxv2), .CCD_nXSG2(nxsg2),
        .AFE_VD(vd), .AFE_HD(hd), .AFE_CLPOB(clpob), .AFE_PBLK(pblk),
        .CPU_VSYNC(vsync), .CPU_HSYNC(hsync), .dbg_state_o(dbg_state)
    );

    assign got = {busy, frame_done, nxv1, nxv2, nxsg2, vd, hd, clpob, pblk, vsync, hsync};

    function automatic int frame_len(input int e);
        return e * H_TOTAL * PIX_DIV + SG_CYC + V_LINES * LINE_CYC;
    endfunction

    // Expected outputs for cycle k of a frame (k = 0 is the first busy cycle).
    function automatic logic [W-1:0] model_vec(input int e, input int k);
        int ex, t, s, l, p, q;
        logic b, d, v1, v2, sg2, vdv, hdv, clp, pb, vs, hs;
        ex = e * H_TOTAL * PIX_DIV;
        t  = frame_len(e);
        b = 0; d = 0; v1 = 1; v2 = 0; sg2 = 1; vdv = 1; hdv = 1; clp = 1; pb = 0; vs = 0; hs = 0;
        if (k == t) begin
            d = 1;
        end else if (k < t) begin
            b = 1;
            if (k >= ex && k < ex + SG_CYC) begin
                s   = k - ex;
                sg2 = !(s >= 8 && s < SG_LEN + 8);
                vdv = !(s < PIX_DIV);
            end else if (k >= ex + SG_CYC) begin
                l  = (k - ex - SG_CYC) % LINE_CYC;
                vs = 1;
                if (l < VXFER_LEN) begin
                    q = l / (VXFER_LEN / 4);
                    case (q)
                        0:       begin v1 = 0; v2 = 0; end
                        1:       begin v1 = 0; v2 = 1; end
                        2:       begin v1 = 1; v2 = 1; end
                        default: begin v1 = 1; v2 = 0; end
                    endcase
                end else begin
                    p   = (l - VXFER_LEN) / PIX_DIV;
                    pb  = 1;
                    hdv = !(p < 8);
                    hs  = (p < H_ACTIVE);
                    clp = !(p >= H_CLAMP_START && p < H_CLAMP_START + H_CLAMP_LEN);
                end
            end
        end
        return {b, d, v1, v2, sg2, vdv, hdv, clp, pb, vs, hs};
    endfunction

    task automatic test_reset();
        rst_n = 0; start = 0; abort = 0; exp_lines = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (got !== IDLE_VEC) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", got, IDLE_VEC);
        end
        rst_n = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (got !== IDLE_VEC) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", got, IDLE_VEC);
        end
    endtask

    task automatic test_full_frame();
        int t, busy_n, done_n, vs_n, hs_pulses, hs_run, hs_bad;
        logic [W-1:0] ev;
        t = frame_len(2);
        busy_n = 0; done_n = 0; vs_n = 0; hs_pulses = 0; hs_run = 0; hs_bad = 0;
        exp_q.delete();
        for (int k = 0; k <= t + 2; k++) exp_q.push_back(model_vec(2, k));
        @(negedge clk); start = 1; exp_lines = 16'd2;
        for (int k = 0; k <= t + 2; k++) begin
            @(negedge clk); start = 0;
            ev = exp_q.pop_front();
            checks++;
            if (got !== ev) begin
                failures++;
                $display("FAIL full_frame cyc=%0d got=%b exp=%b", k, got, ev);
            end
            busy_n += int'(busy); done_n += int'(frame_done); vs_n += int'(vsync);
            if (hsync) hs_run++;
            else if (hs_run != 0) begin
                hs_pulses++;
                if (hs_run != H_ACTIVE * PIX_DIV) hs_bad++;
                hs_run = 0;
            end
        end
        checks++;
        if (busy_n != 294) begin failures++; $display("FAIL full_busy_len got=%0d exp=294", busy_n); end
        checks++;
        if (done_n != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_n); end
        checks++;
        if (vs_n != 192) begin failures++; $display("FAIL full_vsync_len got=%0d exp=192", vs_n); end
        checks++;
        if (hs_pulses != 4 || hs_bad != 0) begin
            failures++;
            $display("FAIL full_hsync pulses=%0d bad=%0d exp pulses=4 bad=0", hs_pulses, hs_bad);
        end
    endtask

    task automatic test_exp_zero();
        int t, busy_n, fall_at;
        logic [W-1:0] ev;
        t = frame_len(0);
        busy_n = 0; fall_at = -1;
        exp_q.delete();
        for (int k = 0; k <= t + 1; k++) exp_q.push_back(model_vec(0, k));
        @(negedge clk); start = 1; exp_lines = 16'd0;
        for (int k = 0; k <= t + 1; k++) begin
            @(negedge clk); start = 0;
            ev = exp_q.pop_front();
            checks++;
            if (got !== ev) begin
                failures++;
                $display("FAIL exp_zero cyc=%0d got=%b exp=%b", k, got, ev);
            end
            busy_n += int'(busy);
            if (!nxsg2 && fall_at < 0) fall_at = k + 1;
        end
        checks++;
        if (fall_at != 9) begin failures++; $display("FAIL exp_zero_sg_fall got=%0d exp=9", fall_at); end
        checks++;
        if (busy_n != 214) begin failures++; $display("FAIL exp_zero_busy_len got=%0d exp=214", busy_n); end
    endtask

    task automatic test_vxfer_waveform();
        int e, t, clp_n;
        logic [W-1:0] ev;
        logic [1:0] vx_seen[$];
        logic [1:0] want, seen;
        e = $urandom_range(0, 1);
        t = frame_len(e);
        clp_n = 0;
        exp_q.delete();
        for (int k = 0; k <= t; k++) exp_q.push_back(model_vec(e, k));
        @(negedge clk); start = 1; exp_lines = 16'(e);
        for (int k = 0; k <= t; k++) begin
            @(negedge clk); start = 0;
            ev = exp_q.pop_front();
            checks++;
            if (got !== ev) begin
                failures++;
                $display("FAIL vxfer_frame cyc=%0d got=%b exp=%b", k, got, ev);
            end
            if (vsync && !pblk) vx_seen.push_back({nxv1, nxv2});
            if (!clpob) clp_n++;
        end
        checks++;
        if (vx_seen.size() != V_LINES * VXFER_LEN) begin
            failures++;
            $display("FAIL vxfer_len got=%0d exp=%0d", vx_seen.size(), V_LINES * VXFER_LEN);
        end else begin
            for (int i = 0; i < V_LINES * VXFER_LEN; i++) begin
                case ((i % VXFER_LEN) / 2)
                    0:       want = 2'b00;
                    1:       want = 2'b01;
                    2:       want = 2'b11;
                    default: want = 2'b10;
                endcase
                seen = vx_seen[i];
                checks++;
                if (seen !== want) begin
                    failures++;
                    $display("FAIL vxfer_phase idx=%0d got=%b exp=%b", i, seen, want);
                end
            end
        end
        checks++;
        if (clp_n != V_LINES * 8) begin
            failures++;
            $display("FAIL clpob_len got=%0d exp=%0d", clp_n, V_LINES * 8);
        end
    endtask

    task automatic test_start_ignored();
        int t;
        logic [W-1:0] ev;
        t = frame_len(1);
        exp_q.delete();
        for (int k = 0; k <= t + 1; k++) exp_q.push_back(model_vec(1, k));
        @(negedge clk); start = 1; exp_lines = 16'd1;
        for (int k = 0; k <= t + 1; k++) begin
            @(negedge clk);
            ev = exp_q.pop_front();
            checks++;
            if (got !== ev) begin
                failures++;
                $display("FAIL start_busy cyc=%0d got=%b exp=%b", k, got, ev);
            end
            if (k < t) begin
                start = 1'($urandom_range(0, 1));
                exp_lines = 16'($urandom_range(0, 5));
            end else begin
                start = 0;
            end
        end
        start = 1; abort = 1; exp_lines = 16'd3;
        @(negedge clk); start = 0; abort = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got !== IDLE_VEC) begin
                failures++;
                $display("FAIL start_with_abort cyc=%0d got=%b exp=%b", k, got, IDLE_VEC);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int e, kab, t, busy_n;
        logic [W-1:0] ev;
        e   = $urandom_range(0, 2);
        kab = e * H_TOTAL * PIX_DIV + SG_CYC + LINE_CYC + VXFER_LEN +
              $urandom_range(0, H_TOTAL * PIX_DIV - 1);
        exp_q.delete();
        for (int k = 0; k <= kab; k++) exp_q.push_back(model_vec(e, k));
        for (int k = 0; k < 6; k++) exp_q.push_back(IDLE_VEC);
        @(negedge clk); start = 1; exp_lines = 16'(e);
        for (int k = 0; k <= kab + 6; k++) begin
            @(negedge clk); start = 0; abort = 0;
            ev = exp_q.pop_front();
            checks++;
            if (got !== ev) begin
                failures++;
                $display("FAIL abort cyc=%0d kab=%0d got=%b exp=%b", k, kab, got, ev);
            end
            if (k == kab) abort = 1;
        end
        t = frame_len(2);
        busy_n = 0;
        exp_q.delete();
        for (int k = 0; k <= t; k++) exp_q.push_back(model_vec(2, k));
        start = 1; exp_lines = 16'd2;
        for (int k = 0; k <= t; k++) begin
            @(negedge clk); start = 0;
            ev = exp_q.pop_front();
            checks++;
            if (got !== ev) begin
                failures++;
                $display("FAIL after_abort cyc=%0d got=%b exp=%b", k, got, ev);
            end
            busy_n += int'(busy);
        end
        checks++;
        if (busy_n != 294) begin failures++; $display("FAIL after_abort_busy_len got=%0d exp=294", busy_n); end
    endtask

    task automatic test_back_to_back();
        int e[3];
        int t;
        logic [W-1:0] ev;
        for (int f = 0; f < 3; f++) e[f] = $urandom_range(0, 3);
        exp_q.delete();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k <= frame_len(e[f]); k++) exp_q.push_back(model_vec(e[f], k));
        @(negedge clk); start = 1; exp_lines = 16'(e[0]);
        for (int f = 0; f < 3; f++) begin
            t = frame_len(e[f]);
            for (int k = 0; k <= t; k++) begin
                @(negedge clk); start = 0;
                ev = exp_q.pop_front();
                checks++;
                if (got !== ev) begin
                    failures++;
                    $display("FAIL back_to_back frame=%0d cyc=%0d got=%b exp=%b", f, k, got, ev);
                end
                if (k == t && f < 2) begin
                    start = 1; exp_lines = 16'(e[f + 1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] ev;
        @(negedge clk); start = 1; exp_lines = 16'd0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk); start = 0;
            ev = model_vec(0, k);
            checks++;
            if (got !== ev) begin
                failures++;
                $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", k, got, ev);
            end
        end
        checks++;
        if (nxsg2 !== 1'b0) begin failures++; $display("FAIL reset_mid_gate_open got=%b exp=0", nxsg2); end
        #2 rst_n = 0;
        #1;
        checks++;
        if (got !== IDLE_VEC) begin
            failures++;
            $display("FAIL reset_mid_async got=%b exp=%b", got, IDLE_VEC);
        end
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (got !== IDLE_VEC) begin
                failures++;
                $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", k, got, IDLE_VEC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_exp_zero();
        test_vxfer_waveform();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
